// File: rtl/up_link_merger_pkg.sv
// up_link_merger_pkg: shared beat width default and source-tag width helper for the root hub up/down paths
package up_link_merger_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/up_link_merger_if.sv
// up_link_merger_if: per-leaf up_rx_* streams in, merged_tx_* tagged stream out, beat_count; master = environment, slave = merger
interface up_link_merger_if
  import up_link_merger_pkg::*;
#(
  parameter int NUM_LEAVES = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SRC_W = src_w(NUM_LEAVES)
);
  logic [DATA_WIDTH*NUM_LEAVES-1:0] up_rx_data;
  logic [NUM_LEAVES-1:0] up_rx_valid;
  logic [NUM_LEAVES-1:0] up_rx_ready;
  logic [DATA_WIDTH-1:0] merged_tx_data;
  logic [SRC_W-1:0] merged_tx_src;
  logic merged_tx_valid;
  logic merged_tx_ready;
  logic [31:0] beat_count;
  modport master (
    output up_rx_data, up_rx_valid, merged_tx_ready,
    input up_rx_ready, merged_tx_data, merged_tx_src, merged_tx_valid, beat_count
  );
  modport slave (
    input up_rx_data, up_rx_valid, merged_tx_ready,
    output up_rx_ready, merged_tx_data, merged_tx_src, merged_tx_valid, beat_count
  );
endinterface

// File: rtl/up_link_merger_link_skid_buffer.sv
// link_skid_buffer: 2-entry valid/ready FIFO with registered ready; in_* from leaf, out_data/out_valid head, pop from arbiter
module link_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic out_valid,
  input  logic pop
);
  logic [WIDTH-1:0] mem [2];
  logic [1:0] cnt, cnt_next;
  logic wp, rp, push;
  assign push = in_valid && in_ready;
  assign cnt_next = cnt + {1'b0, push} - {1'b0, pop};
  assign out_valid = cnt != 2'd0;
  assign out_data = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      cnt <= 2'd0;
      wp <= 1'b0;
      rp <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      cnt <= cnt_next;
      in_ready <= (cnt_next <= 2'd1);
    end
endmodule

// File: rtl/up_link_merger.sv
// up_link_merger: round-robin merge of per-leaf skid-buffered streams into one registered, source-tagged stream; ports clk, reset, bus (slave)
module up_link_merger
  import up_link_merger_pkg::*;
#(
  parameter int NUM_LEAVES = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SRC_W = src_w(NUM_LEAVES)
) (
  input logic clk,
  input logic reset,
  up_link_merger_if.slave bus
);
  logic [NUM_LEAVES-1:0] ne, pop, rdy;
  logic [DATA_WIDTH-1:0] head [NUM_LEAVES];
  logic [DATA_WIDTH-1:0] dat;
  logic [SRC_W-1:0] ptr, gnt, gi, src;
  logic vld, found, load;
  logic [31:0] cnt;
  int idx;
  for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_leaf
    link_skid_buffer #(.WIDTH(DATA_WIDTH)) u_skid (
      .clk(clk),
      .reset(reset),
      .in_data(bus.up_rx_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .in_valid(bus.up_rx_valid[i]),
      .in_ready(rdy[i]),
      .out_data(head[i]),
      .out_valid(ne[i]),
      .pop(pop[i])
    );
  end
  // scan downward so the closest non-empty leaf at or after ptr is written last and wins
  always_comb begin
    gnt = '0;
    gi = '0;
    found = 1'b0;
    idx = 0;
    for (int k = NUM_LEAVES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_LEAVES;
      gi = SRC_W'(idx);
      if (ne[gi]) begin
        gnt = gi;
        found = 1'b1;
      end
    end
  end
  assign load = (!vld || bus.merged_tx_ready) && found;
  always_comb begin
    pop = '0;
    pop[gnt] = load;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld <= 1'b0;
      dat <= '0;
      src <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      if (load) begin
        vld <= 1'b1;
        dat <= head[gnt];
        src <= gnt;
        ptr <= (gnt == SRC_W'(NUM_LEAVES - 1)) ? '0 : gnt + 1'b1;
      end else if (bus.merged_tx_ready) vld <= 1'b0;
      if (vld && bus.merged_tx_ready) cnt <= cnt + 32'd1;
    end
  assign bus.up_rx_ready = rdy;
  assign bus.merged_tx_data = dat;
  assign bus.merged_tx_src = src;
  assign bus.merged_tx_valid = vld;
  assign bus.beat_count = cnt;
endmodule

// File: tb/tb_up_link_merger.sv
// tb_up_link_merger: directed scenarios plus random traffic checked against a queue-based reference model
module tb_up_link_merger;
  logic clk = 1'b0;
  logic reset = 1'b0;
  up_link_merger_if #(.NUM_LEAVES(4), .DATA_WIDTH(64)) bus ();
  up_link_merger #(.NUM_LEAVES(4), .DATA_WIDTH(64)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_chk, n_fail, ncyc;
  logic [63:0] q [4][$];
  logic [63:0] sq [4][$];
  logic [63:0] exp_q [4][$];
  logic mv;
  logic [63:0] md;
  logic [1:0] ms;
  logic [31:0] mcnt;
  int mptr;
  logic [3:0] mrdy;
  logic [1:0] log_src [$];
  logic [63:0] log_dat [$];
  int log_cyc [$];
  bit gaps, rnd_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.up_rx_valid[i] = (sq[i].size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      if (sq[i].size() > 0) bus.up_rx_data[i*64 +: 64] = sq[i][0];
      else bus.up_rx_data[i*64 +: 64] = 64'd0;
    end
    if (rnd_rdy) bus.merged_tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int leaf, input logic [63:0] d);
    sq[leaf].push_back(d);
    exp_q[leaf].push_back(d);
  endtask

  task automatic cyc();
    logic [3:0] acc;
    int g, j;
    for (int i = 0; i < 4; i++) begin
      acc[i] = bus.up_rx_valid[i] && mrdy[i];
      if (bus.up_rx_valid[i] && bus.up_rx_ready[i])
        chk($sformatf("no_overflow_leaf%0d", i), 64'(q[i].size() < 2), 64'd1);
    end
    if (bus.merged_tx_valid && bus.merged_tx_ready) begin
      log_src.push_back(bus.merged_tx_src);
      log_dat.push_back(bus.merged_tx_data);
      log_cyc.push_back(ncyc);
    end
    @(posedge clk);
    ncyc++;
    if (mv && bus.merged_tx_ready) mcnt++;
    if (!mv || bus.merged_tx_ready) begin
      g = -1;
      for (int k = 0; k < 4; k++) begin
        j = (mptr + k) % 4;
        if (g < 0 && q[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        md = q[g].pop_front();
        ms = 2'(g);
        mv = 1'b1;
        mptr = (g + 1) % 4;
      end else mv = 1'b0;
    end
    for (int i = 0; i < 4; i++) if (acc[i]) q[i].push_back(sq[i].pop_front());
    for (int i = 0; i < 4; i++) mrdy[i] = q[i].size() <= 1;
    #1;
    chk("valid", bus.merged_tx_valid, mv);
    chk("data", bus.merged_tx_data, md);
    chk("src", bus.merged_tx_src, ms);
    chk("up_ready", bus.up_rx_ready, mrdy);
    chk("beat_count", bus.beat_count, mcnt);
    drive();
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    mv = 1'b0;
    md = '0;
    ms = '0;
    mcnt = '0;
    mptr = 0;
    mrdy = '0;
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      sq[i].delete();
      exp_q[i].delete();
    end
    log_src.delete();
    log_dat.delete();
    log_cyc.delete();
    drive();
    #1;
    chk("rst_valid", bus.merged_tx_valid, 0);
    chk("rst_data", bus.merged_tx_data, 0);
    chk("rst_src", bus.merged_tx_src, 0);
    chk("rst_up_ready", bus.up_rx_ready, 0);
    chk("rst_beat_count", bus.beat_count, 0);
    #(hold);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int c = 0; c < budget && log_src.size() < n; c++) cyc();
    chk("deliver_count", 64'(log_src.size()), 64'(n));
  endtask

  task automatic check_order();
    int s;
    while (log_src.size() > 0) begin
      s = log_src.pop_front();
      chk("extra_beat", 64'(exp_q[s].size() > 0), 64'd1);
      if (exp_q[s].size() > 0) chk("leaf_order", log_dat.pop_front(), exp_q[s].pop_front());
      else void'(log_dat.pop_front());
    end
    log_cyc.delete();
    chk("lost_beats", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);
  endtask

  initial begin
    int tot;
    bus.merged_tx_ready = 1'b1;
    #2;
    do_reset(100);
    cyc();
    chk("post_rst_ready", bus.up_rx_ready, 4'b1111);
    chk("post_rst_valid", bus.merged_tx_valid, 0);
    send(2, 64'h0000_0002_DEAD_BEEF);
    drive();
    cyc();
    cyc();
    chk("single_valid", bus.merged_tx_valid, 1);
    chk("single_data", bus.merged_tx_data, 64'h0000_0002_DEAD_BEEF);
    chk("single_src", bus.merged_tx_src, 2);
    cyc();
    chk("single_count", bus.beat_count, 1);
    do_reset(20);
    cyc();
    for (int s = 0; s < 8; s++) for (int l = 0; l < 4; l++) send(l, {32'(l), 32'(s)});
    drive();
    run_until(32, 200);
    for (int k = 0; k < 32 && k < log_src.size(); k++) begin
      chk("sat_src", log_src[k], 64'(k % 4));
      chk("sat_data", log_dat[k], {32'(k % 4), 32'(k / 4)});
      chk("sat_no_bubble", 64'(log_cyc[k] - log_cyc[0]), 64'(k));
    end
    chk("sat_count", bus.beat_count, 32);
    check_order();
    bus.merged_tx_ready = 1'b0;
    do_reset(20);
    cyc();
    for (int l = 0; l < 4; l++) for (int s = 0; s < 3; s++) send(l, {$urandom, $urandom});
    drive();
    repeat (20) cyc();
    chk("bp_up_ready", bus.up_rx_ready, 4'b0000);
    chk("bp_valid", bus.merged_tx_valid, 1);
    chk("bp_src", bus.merged_tx_src, 0);
    chk("bp_no_delivery", 64'(log_src.size()), 64'd0);
    bus.merged_tx_ready = 1'b1;
    run_until(12, 100);
    check_order();
    do_reset(20);
    cyc();
    for (int s = 0; s < 6; s++) begin
      send(1, {$urandom, $urandom});
      send(3, {$urandom, $urandom});
    end
    drive();
    run_until(12, 100);
    for (int k = 0; k < 12 && k < log_src.size(); k++) begin
      chk("skew_src", log_src[k], (k % 2 == 0) ? 64'd1 : 64'd3);
      chk("skew_no_bubble", 64'(log_cyc[k] - log_cyc[0]), 64'(k));
    end
    check_order();
    bus.merged_tx_ready = 1'b0;
    for (int s = 0; s < 3; s++) send(0, {$urandom, $urandom});
    for (int s = 0; s < 2; s++) send(1, {$urandom, $urandom});
    drive();
    repeat (8) cyc();
    chk("mid_count_before", bus.beat_count, 12);
    chk("mid_valid_before", bus.merged_tx_valid, 1);
    do_reset(30);
    bus.merged_tx_ready = 1'b1;
    drive();
    repeat (10) cyc();
    chk("mid_no_stale", 64'(log_src.size()), 64'd0);
    chk("mid_valid_after", bus.merged_tx_valid, 0);
    gaps = 1'b1;
    rnd_rdy = 1'b1;
    tot = 0;
    for (int l = 0; l < 4; l++) begin
      int n;
      n = $urandom_range(0, 10);
      tot += n;
      for (int s = 0; s < n; s++) send(l, {$urandom, $urandom});
    end
    drive();
    run_until(tot, 1500);
    check_order();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/up_link_merger.md
Name: up_link_merger

Overview:
- Merges the NUM_LEAVES leaf-to-root 64-bit valid/ready streams into one upstream stream. This is the upward counterpart of the root's per-leaf downward fan-out.
- Sits in the root hub between the per-leaf up_rx links and the root's single message consumer.
- Each leaf input has a 2-entry skid buffer. A round-robin arbiter selects the next beat, and a single output register drives the merged stream, tagged with the source leaf index.

Parameters:
- NUM_LEAVES, 4, number of leaf input links (>=2).
- DATA_WIDTH, 64, message beat width.
- SRC_W, $clog2(NUM_LEAVES), width of the source tag.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- up_rx_data  in  DATA_WIDTH*NUM_LEAVES  leaf i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- up_rx_valid  in  NUM_LEAVES  per-leaf beat valid.
- up_rx_ready  out  NUM_LEAVES  per-leaf ready, registered.
- merged_tx_data  out  DATA_WIDTH  merged beat, passed through unmodified.
- merged_tx_src  out  SRC_W  index of the leaf that produced merged_tx_data.
- merged_tx_valid  out  1  merged beat valid.
- merged_tx_ready  in  1  downstream ready.
- beat_count  out  32  total beats delivered downstream; wraps modulo 2^32.

Behaviour:
- Reset: only clk and reset are fixed by prior decision (one clock, asynchronous active-high reset). On reset, all outputs and all state go to 0: skid buffers empty, up_rx_ready=0, merged_tx_valid=0, merged_tx_data=0, merged_tx_src=0, beat_count=0, round-robin pointer=0.
- Reset asserted mid-operation discards all buffered beats immediately, with no partial output.
- Input transfer: occurs on a rising edge where up_rx_valid[i]&&up_rx_ready[i]. A beat presented while ready=0 is not taken; the leaf holds it.
- Skid buffer: 2-entry FIFO per leaf with occupancy cnt[i] in 0..2.
  - up_rx_ready[i] is registered and updated each edge to (cnt_next[i] <= 1). It therefore rises on the first edge after reset deasserts.
  - Overflow cannot occur: push with cnt=2 is impossible by construction. The bench asserts this.
  - Simultaneous push and pop in one cycle leaves cnt unchanged and preserves FIFO order.
- Output register load: out_free = !merged_tx_valid || merged_tx_ready. When out_free and any skid buffer is non-empty:
  - The arbiter grants the first non-empty leaf scanning from ptr, ptr+1, ..., wrapping at NUM_LEAVES.
  - That leaf's head is popped and loaded into the output register with merged_tx_src = granted index.
  - ptr becomes granted index + 1, wrapping to 0 after NUM_LEAVES-1.
- Output register, no load: if out_free and no leaf is non-empty, merged_tx_valid goes to 0 on a completed transfer. If !out_free, the register holds data, src and valid stable.
- Grant timing: at most one grant per cycle.
- Latency: a beat accepted at edge N reaches the skid buffer and is visible at the output after edge N+1 (merged_tx_valid high) when there is no contention and the output is free. Minimum latency is 2 edges.
- Throughput: 1 beat/cycle aggregate while merged_tx_ready=1. With all leaves saturated, each leaf receives exactly one grant per NUM_LEAVES cycles.
- Ordering: per-leaf order is preserved. No ordering across leaves is guaranteed beyond round-robin.
- beat_count: increments by 1 on each edge with merged_tx_valid&&merged_tx_ready; wraps 0xFFFFFFFF->0.
- Backpressure: with merged_tx_ready held 0, each leaf absorbs 2 beats, then its up_rx_ready=0. No beat is lost or duplicated.

Decomposition:
- Shared package: DATA_WIDTH default (64) and the SRC_W derivation function (clog2), reused by the root hub down-path.
- Sub-module link_skid_buffer: 2-entry valid/ready FIFO with registered ready, parameterised by width, instantiated NUM_LEAVES times in a generate loop.
- Arbiter and output register stay in the top module.

Test Plan:
- Post-reset: hold reset 100 ns, then release -> all outputs 0 during reset; up_rx_ready=4'b1111 one edge after release; merged_tx_valid=0.
- Single beat: leaf 2 sends 0x0000_0002_DEAD_BEEF for 1 cycle, merged_tx_ready=1 -> merged_tx_valid high 2 edges later with that data, merged_tx_src=2; beat_count=1.
- Saturation: all 4 leaves stream 8 beats each (data = leaf<<32 | seq), ready=1 -> 32 beats out, src sequence 0,1,2,3 repeating, per-leaf seq increasing, beat_count=32.
- Backpressure: merged_tx_ready=0 for 20 cycles, all leaves valid -> 1 beat held at output, 2 beats per leaf buffered, up_rx_ready=0000. Then release ready -> all 9 buffered beats delivered in arbitration order, none lost or duplicated.
- Skewed load: only leaves 1 and 3 active, ptr starting at 0 -> alternating src 1,3,1,3 with back-to-back valid and no bubble cycles.
- Reset mid-stream: assert reset while 5 beats are buffered -> merged_tx_valid=0 and beat_count=0 immediately; no old beat appears after release.
